// File: rtl/Purple_Jade_pkg.sv
//==============================================================================
// Module : Purple_Jade_pkg
// Desc   : Global widths, CDB broadcast format and ALU reservation-station entry.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package Purple_Jade_pkg;

    localparam int WORD_SIZE_P  = 32;
    localparam int WIDTH_OP     = 4;
    localparam int ROB_ENTRY    = 16;
    localparam int NUM_PHYS_REG = 64;
    localparam int FLAG_W       = 4;

    localparam int TAG_W = $clog2(NUM_PHYS_REG);
    localparam int ROB_W = $clog2(ROB_ENTRY);

    localparam logic [WIDTH_OP-1:0] ADD_OP = 4'd0;
    localparam logic [WIDTH_OP-1:0] SUB_OP = 4'd1;

    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       dest;
        logic [FLAG_W-1:0]      flags;
        logic [WORD_SIZE_P-1:0] result;
    } CDB_t;

    localparam int CDB_WIDTH = $bits(CDB_t);

    typedef struct packed {
        logic                   rdy;
        logic [TAG_W-1:0]       tag;
        logic [WORD_SIZE_P-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                valid;
        logic [WIDTH_OP-1:0] op;
        logic                w_v;
        rs_src_t             src1;
        rs_src_t             src2;
        logic [ROB_W-1:0]    rob;
        logic [TAG_W-1:0]    dest;
    } alu_rs_entry_t;

    // Capture a CDB result into a source operand that is still waiting on its tag.
    function automatic rs_src_t wake_src(input rs_src_t s, input CDB_t c);
        rs_src_t r;
        r = s;
        if (c.valid && !s.rdy && (c.dest == s.tag)) begin
            r.rdy = 1'b1;
            r.val = c.result;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rs_if.sv
//==============================================================================
// Module : alu_rs_if
// Desc   : Dispatch handshake into, and issue bundle out of, the ALU station.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface alu_rs_if;
    import Purple_Jade_pkg::*;

    logic                   disp_v_i;
    logic                   disp_rdy_o;
    logic [WIDTH_OP-1:0]    disp_op_i;
    logic                   disp_w_v_i;
    logic                   disp_src1_rdy_i;
    logic [TAG_W-1:0]       disp_src1_tag_i;
    logic [WORD_SIZE_P-1:0] disp_src1_val_i;
    logic                   disp_src2_rdy_i;
    logic [TAG_W-1:0]       disp_src2_tag_i;
    logic [WORD_SIZE_P-1:0] disp_src2_val_i;
    logic [ROB_W-1:0]       disp_rob_i;
    logic [TAG_W-1:0]       disp_dest_i;

    logic                   exe_v_o;
    logic                   w_v_o;
    logic [WIDTH_OP-1:0]    opcode_o;
    logic [WORD_SIZE_P-1:0] operand1_o;
    logic [WORD_SIZE_P-1:0] operand2_o;
    logic [ROB_W-1:0]       rob_dest_o;
    logic [TAG_W-1:0]       reg_dest_o;

    modport slave (
        input  disp_v_i, disp_op_i, disp_w_v_i,
               disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
               disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
               disp_rob_i, disp_dest_i,
        output disp_rdy_o,
               exe_v_o, w_v_o, opcode_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
    );

    modport master (
        output disp_v_i, disp_op_i, disp_w_v_i,
               disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
               disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
               disp_rob_i, disp_dest_i,
        input  disp_rdy_o,
               exe_v_o, w_v_o, opcode_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
    );

endinterface

`default_nettype wire

// File: rtl/rs_age_matrix.sv
//==============================================================================
// Module : rs_age_matrix
// Desc   : Relative-age tracker; grants the oldest requesting entry (one-hot).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rs_age_matrix #(
    parameter int N = 4
) (
    input  wire logic         clk_i,
    input  wire logic         reset_n_i,
    input  wire logic         flush_i,
    input  wire logic [N-1:0] alloc_i,
    input  wire logic [N-1:0] free_i,
    input  wire logic [N-1:0] req_i,
    output logic      [N-1:0] grant_o
);

    logic [N-1:0] r_occ;
    logic [N-1:0] r_age [N];

    // Row i bit j set: entry i is older than entry j. The diagonal stays clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_occ <= '0;
            for (int i = 0; i < N; i++) r_age[i] <= '0;
        end else if (flush_i) begin
            r_occ <= '0;
            for (int i = 0; i < N; i++) r_age[i] <= '0;
        end else begin
            r_occ <= (r_occ & ~free_i) | alloc_i;
            for (int i = 0; i < N; i++) begin
                if (alloc_i[i])
                    r_age[i] <= ~r_occ & ~alloc_i;
                else if (r_occ[i])
                    r_age[i] <= r_age[i] | alloc_i;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        logic [N-1:0] w_older;
        always_comb begin
            for (int j = 0; j < N; j++) w_older[j] = r_age[j][gi];
        end
        assign grant_o[gi] = req_i[gi] & ~|(req_i & w_older);
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
//==============================================================================
// Module : alu_rs
// Desc   : ADD/SUB reservation station with CDB wakeup and oldest-first issue.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_rs
    import Purple_Jade_pkg::*;
#(
    parameter int RS_ENTRY = 4
) (
    input  wire logic                 clk_i,
    input  wire logic                 reset_n_i,
    input  wire logic                 flush_i,
    input  wire logic [CDB_WIDTH-1:0] cdb_i,
    alu_rs_if.slave                   rs
);

    alu_rs_entry_t         r_ent [RS_ENTRY];
    alu_rs_entry_t         w_new;
    CDB_t                  w_cdb;
    logic [RS_ENTRY-1:0]   w_valid;
    logic [RS_ENTRY-1:0]   w_ready;
    logic [RS_ENTRY-1:0]   w_alloc;
    logic [RS_ENTRY-1:0]   w_grant;
    logic                  w_fire;
    logic                  w_found;

    logic                   r_exe_v;
    logic                   r_w_v;
    logic [WIDTH_OP-1:0]    r_op;
    logic [WORD_SIZE_P-1:0] r_opnd1;
    logic [WORD_SIZE_P-1:0] r_opnd2;
    logic [ROB_W-1:0]       r_rob;
    logic [TAG_W-1:0]       r_dest;

    assign w_cdb = CDB_t'(cdb_i);

    for (genvar gi = 0; gi < RS_ENTRY; gi++) begin : g_vec
        assign w_valid[gi] = r_ent[gi].valid;
        assign w_ready[gi] = r_ent[gi].valid & r_ent[gi].src1.rdy & r_ent[gi].src2.rdy;
    end

    // Readiness sees only held state, so a slot freed by this cycle's issue is not offered.
    assign rs.disp_rdy_o = ~&w_valid;
    assign w_fire        = rs.disp_v_i & rs.disp_rdy_o & ~flush_i;

    always_comb begin
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < RS_ENTRY; i++) begin
            if (!w_valid[i] && !w_found) begin
                w_alloc[i] = w_fire;
                w_found    = 1'b1;
            end
        end
    end

    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.op       = rs.disp_op_i;
        w_new.w_v      = rs.disp_w_v_i;
        w_new.src1.rdy = rs.disp_src1_rdy_i;
        w_new.src1.tag = rs.disp_src1_tag_i;
        w_new.src1.val = rs.disp_src1_val_i;
        w_new.src2.rdy = rs.disp_src2_rdy_i;
        w_new.src2.tag = rs.disp_src2_tag_i;
        w_new.src2.val = rs.disp_src2_val_i;
        w_new.rob      = rs.disp_rob_i;
        w_new.dest     = rs.disp_dest_i;
        w_new.src1     = wake_src(w_new.src1, w_cdb);
        w_new.src2     = wake_src(w_new.src2, w_cdb);
    end

    rs_age_matrix #(.N(RS_ENTRY)) u_age (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .alloc_i   (w_alloc),
        .free_i    (w_grant),
        .req_i     (w_ready),
        .grant_o   (w_grant)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < RS_ENTRY; i++) r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                if (flush_i) begin
                    r_ent[i].valid <= 1'b0;
                end else if (w_alloc[i]) begin
                    r_ent[i] <= w_new;
                end else begin
                    if (w_grant[i]) r_ent[i].valid <= 1'b0;
                    r_ent[i].src1 <= wake_src(r_ent[i].src1, w_cdb);
                    r_ent[i].src2 <= wake_src(r_ent[i].src2, w_cdb);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_exe_v <= 1'b0;
            r_w_v   <= 1'b0;
            r_op    <= '0;
            r_opnd1 <= '0;
            r_opnd2 <= '0;
            r_rob   <= '0;
            r_dest  <= '0;
        end else if (flush_i) begin
            r_exe_v <= 1'b0;
        end else begin
            r_exe_v <= |w_grant;
            for (int i = 0; i < RS_ENTRY; i++) begin
                if (w_grant[i]) begin
                    r_w_v   <= r_ent[i].w_v;
                    r_op    <= r_ent[i].op;
                    r_opnd1 <= r_ent[i].src1.val;
                    r_opnd2 <= r_ent[i].src2.val;
                    r_rob   <= r_ent[i].rob;
                    r_dest  <= r_ent[i].dest;
                end
            end
        end
    end

    assign rs.exe_v_o    = r_exe_v;
    assign rs.w_v_o      = r_w_v;
    assign rs.opcode_o   = r_op;
    assign rs.operand1_o = r_opnd1;
    assign rs.operand2_o = r_opnd2;
    assign rs.rob_dest_o = r_rob;
    assign rs.reg_dest_o = r_dest;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
//==============================================================================
// Module : tb_alu_rs
// Desc   : Directed and random stimulus against an in-order queue model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_alu_rs;
    import Purple_Jade_pkg::*;

    localparam int RS_ENTRY = 4;

    logic                   clk_i     = 1'b0;
    logic                   reset_n_i = 1'b0;
    logic                   flush_i   = 1'b0;
    logic                   cdb_v     = 1'b0;
    logic [TAG_W-1:0]       cdb_dest  = '0;
    logic [FLAG_W-1:0]      cdb_flags = '0;
    logic [WORD_SIZE_P-1:0] cdb_res   = '0;
    logic [CDB_WIDTH-1:0]   cdb_i;

    assign cdb_i = {cdb_v, cdb_dest, cdb_flags, cdb_res};

    alu_rs_if ifc ();

    alu_rs #(.RS_ENTRY(RS_ENTRY)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .cdb_i     (cdb_i),
        .rs        (ifc)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: a list of waiting ops in dispatch order; the first ready one issues.
    typedef struct {
        logic [WIDTH_OP-1:0]    op;
        logic                   w;
        logic                   r1;
        logic [TAG_W-1:0]       t1;
        logic [WORD_SIZE_P-1:0] v1;
        logic                   r2;
        logic [TAG_W-1:0]       t2;
        logic [WORD_SIZE_P-1:0] v2;
        logic [ROB_W-1:0]       rob;
        logic [TAG_W-1:0]       dest;
    } mop_t;

    mop_t q[$];
    mop_t exp_op;
    logic exp_v = 1'b0;
    int   issued_rob[$];

    function automatic mop_t wake(input mop_t m);
        mop_t r = m;
        if (cdb_v && !r.r1 && r.t1 == cdb_dest) begin r.r1 = 1'b1; r.v1 = cdb_res; end
        if (cdb_v && !r.r2 && r.t2 == cdb_dest) begin r.r2 = 1'b1; r.v2 = cdb_res; end
        return r;
    endfunction

    task automatic idle();
        ifc.disp_v_i = 1'b0;
        cdb_v        = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic drive(input logic [WIDTH_OP-1:0] op, input logic r1, input int t1, input int v1,
                         input logic r2, input int t2, input int v2, input int rob, input int dest);
        ifc.disp_v_i        = 1'b1;
        ifc.disp_op_i       = op;
        ifc.disp_w_v_i      = 1'b1;
        ifc.disp_src1_rdy_i = r1;
        ifc.disp_src1_tag_i = TAG_W'(t1);
        ifc.disp_src1_val_i = WORD_SIZE_P'(v1);
        ifc.disp_src2_rdy_i = r2;
        ifc.disp_src2_tag_i = TAG_W'(t2);
        ifc.disp_src2_val_i = WORD_SIZE_P'(v2);
        ifc.disp_rob_i      = ROB_W'(rob);
        ifc.disp_dest_i     = TAG_W'(dest);
    endtask

    task automatic cdb(input int tag, input int res);
        cdb_v     = 1'b1;
        cdb_dest  = TAG_W'(tag);
        cdb_res   = WORD_SIZE_P'(res);
        cdb_flags = FLAG_W'($urandom);
    endtask

    // One clock: predict from the current inputs, advance, compare the issue port.
    task automatic cycle();
        int   sel;
        bit   acc;
        mop_t n;
        check("disp_rdy", 64'(ifc.disp_rdy_o), 64'(q.size() < RS_ENTRY));
        sel = -1;
        for (int i = 0; i < q.size(); i++)
            if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
        acc = ifc.disp_v_i && (q.size() < RS_ENTRY);
        if (flush_i) begin
            q.delete();
            exp_v = 1'b0;
        end else begin
            exp_v = (sel >= 0);
            if (exp_v) begin
                exp_op = q[sel];
                q.delete(sel);
            end
            for (int i = 0; i < q.size(); i++) q[i] = wake(q[i]);
            if (acc) begin
                n.op = ifc.disp_op_i;          n.w  = ifc.disp_w_v_i;
                n.r1 = ifc.disp_src1_rdy_i;    n.t1 = ifc.disp_src1_tag_i;
                n.v1 = ifc.disp_src1_val_i;    n.r2 = ifc.disp_src2_rdy_i;
                n.t2 = ifc.disp_src2_tag_i;    n.v2 = ifc.disp_src2_val_i;
                n.rob = ifc.disp_rob_i;        n.dest = ifc.disp_dest_i;
                q.push_back(wake(n));
            end
        end
        @(posedge clk_i);
        #1;
        check("exe_v", 64'(ifc.exe_v_o), 64'(exp_v));
        if (exp_v) begin
            check("issue_ctl", 64'({ifc.opcode_o, ifc.w_v_o, ifc.rob_dest_o, ifc.reg_dest_o}),
                               64'({exp_op.op, exp_op.w, exp_op.rob, exp_op.dest}));
            check("issue_opnd", {ifc.operand1_o, ifc.operand2_o}, {exp_op.v1, exp_op.v2});
            issued_rob.push_back(int'(exp_op.rob));
        end
    endtask

    initial begin
        idle();
        drive(ADD_OP, 0, 0, 0, 0, 0, 0, 0, 0);
        ifc.disp_v_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        check("reset_exe_v", 64'(ifc.exe_v_o), 64'd0);
        check("reset_rdy", 64'(ifc.disp_rdy_o), 64'd1);

        // Reset with three waiting entries.
        for (int i = 0; i < 3; i++) begin
            drive(ADD_OP, 0, 40 + i, 0, 1, 0, 1, i, i);
            cycle();
        end
        idle();
        #2 reset_n_i = 1'b0;
        #1 check("async_reset_exe_v", 64'(ifc.exe_v_o), 64'd0);
        #2 reset_n_i = 1'b1;
        q.delete();
        exp_v = 1'b0;
        @(posedge clk_i);
        #1;
        check("post_reset_rdy", 64'(ifc.disp_rdy_o), 64'd1);
        check("post_reset_exe_v", 64'(ifc.exe_v_o), 64'd0);
        cdb(40, 1);
        cycle();
        idle();
        cycle();

        // Both sources ready: issue two edges after dispatch.
        drive(ADD_OP, 1, 0, 5, 1, 0, 3, 1, 2);
        cycle();
        idle();
        cycle();
        check("add_op1", 64'(ifc.operand1_o), 64'd5);
        check("add_op2", 64'(ifc.operand2_o), 64'd3);

        // src2 waits on tag 7; broadcast arrives two cycles after dispatch.
        drive(ADD_OP, 1, 0, 'h21, 0, 7, 0, 2, 3);
        cycle();
        idle();
        cycle();
        cdb(7, 'h10);
        cycle();
        idle();
        cycle();
        check("wake_exe_v", 64'(ifc.exe_v_o), 64'd1);
        check("wake_op2", 64'(ifc.operand2_o), 64'h10);

        // Same-cycle bypass of tag 9 at dispatch.
        drive(SUB_OP, 0, 9, 0, 1, 0, 4, 3, 4);
        cdb(9, 'h99);
        cycle();
        idle();
        cycle();
        check("bypass_op1", 64'(ifc.operand1_o), 64'h99);

        // Fill, drop an extra dispatch, wake in reverse, expect age order.
        for (int i = 0; i < RS_ENTRY; i++) begin
            drive(SUB_OP, 0, 50 + i, 0, 0, 20, 0, i, i);
            cycle();
        end
        check("full_rdy", 64'(ifc.disp_rdy_o), 64'd0);
        drive(ADD_OP, 1, 0, 1, 1, 0, 1, 9, 9);
        cycle();
        for (int i = RS_ENTRY - 1; i >= 0; i--) begin
            idle();
            cdb(50 + i, 100 + i);
            cycle();
        end
        issued_rob.delete();
        idle();
        cdb(20, 'h20);
        cycle();
        idle();
        repeat (RS_ENTRY + 1) cycle();
        check("age_count", 64'(issued_rob.size()), 64'(RS_ENTRY));
        for (int i = 0; i < issued_rob.size(); i++)
            check("age_order", 64'(issued_rob[i]), 64'(i));

        // Flush with two held entries and one op in the issue register.
        drive(ADD_OP, 0, 30, 0, 1, 0, 0, 5, 5);
        cycle();
        drive(ADD_OP, 0, 30, 0, 1, 0, 0, 6, 6);
        cycle();
        drive(ADD_OP, 1, 0, 7, 1, 0, 8, 7, 7);
        cycle();
        idle();
        cycle();
        check("pre_flush_exe_v", 64'(ifc.exe_v_o), 64'd1);
        flush_i = 1'b1;
        cycle();
        check("flush_exe_v", 64'(ifc.exe_v_o), 64'd0);
        check("flush_rdy", 64'(ifc.disp_rdy_o), 64'd1);
        idle();
        cdb(30, 'h30);
        cycle();
        idle();
        repeat (3) cycle();

        // Random traffic.
        repeat (1500) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                drive($urandom_range(0, 1) ? ADD_OP : SUB_OP,
                      1'($urandom_range(0, 1)), $urandom_range(0, 7), int'($urandom),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7), int'($urandom),
                      $urandom_range(0, ROB_ENTRY - 1), $urandom_range(0, NUM_PHYS_REG - 1));
            ifc.disp_w_v_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) cdb($urandom_range(0, 7), int'($urandom));
            flush_i = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle();
        repeat (RS_ENTRY + 2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
